wavelet_level_scheduler: RTL and testbench

Sequences a multi-level dyadic wavelet decomposition over one frame of samples. Accepts input samples through a valid/ready handshake and counts them within the frame. Issues one-cycle enable ticks to each decomposition level at that level's decimated rate (level k every 2^(k+1) samples). Drains the level pipeline and then signals frame completion. Sits between the sample source and the per-level filter stages, and replaces free-running divided clocks with clock enables on the single system clock.

---
 rtl/wavelet_pkg.sv | 23 ++
 rtl/wavelet_level_scheduler_if.sv | 24 ++
 rtl/wavelet_tick_decoder.sv | 23 ++
 rtl/wavelet_level_scheduler.sv | 102 ++++++++++
 tb/tb_wavelet_level_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wavelet_pkg.sv
// Shared types and helpers for the wavelet level scheduler and its level-rate consumers.
package wavelet_pkg;

    localparam int unsigned MAX_LEVELS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Bit k is set when (idx+1) is a multiple of 2^(k+1), i.e. the low k+1 bits of idx are all ones.
    function automatic logic [MAX_LEVELS-1:0] tick_mask(input logic [MAX_LEVELS-1:0] idx);
        logic [MAX_LEVELS-1:0] m;
        m[0] = idx[0];
        for (int unsigned k = 1; k < MAX_LEVELS; k++) begin
            m[k] = m[k-1] & idx[k];
        end
        return m;
    endfunction

endpackage

// File: rtl/wavelet_level_scheduler_if.sv
// Control, sample handshake and level-enable bundle between sample source and scheduler.
interface wavelet_level_scheduler_if #(
    parameter int unsigned LEVELS = 3,
    parameter int unsigned CNT_W  = 6
);
    logic              start;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [LEVELS-1:0] lvl_en;
    logic [CNT_W-1:0]  sample_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, clr, in_valid,
        input  in_ready, lvl_en, sample_idx, busy, done
    );

    modport slave (
        input  start, clr, in_valid,
        output in_ready, lvl_en, sample_idx, busy, done
    );
endinterface

// File: rtl/wavelet_tick_decoder.sv
// Registered per-level enable ticks derived from an accepted sample index.
module wavelet_tick_decoder
    import wavelet_pkg::*;
#(
    parameter int unsigned LEVELS = 3,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              accept,
    input  logic [CNT_W-1:0]  idx,
    output logic [LEVELS-1:0] lvl_en
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_en <= '0;
        end else begin
            lvl_en <= accept ? LEVELS'(tick_mask(MAX_LEVELS'(idx))) : '0;
        end
    end

endmodule

// File: rtl/wavelet_level_scheduler.sv
// Frame sequencer: counts accepted samples, issues decimated level enables, flushes, then pulses done.
module wavelet_level_scheduler
    import wavelet_pkg::*;
#(
    parameter int unsigned LEVELS    = 3,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned FLUSH_CYC = 4,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
    input logic                      clk,
    input logic                      rstn,
    wavelet_level_scheduler_if.slave bus
);

    localparam int unsigned      FL_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
    localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx_q;
    logic [FL_W-1:0]  flush_cnt;
    logic             rdy_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    assign accept         = bus.in_valid & rdy_q & ~bus.clr;
    assign bus.in_ready   = rdy_q;
    assign bus.sample_idx = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    wavelet_tick_decoder #(
        .LEVELS (LEVELS),
        .CNT_W  (CNT_W)
    ) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .accept (accept),
        .idx    (cnt),
        .lvl_en (bus.lvl_en)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            flush_cnt <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.clr) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            flush_cnt <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        idx_q <= cnt;
                        cnt   <= cnt + CNT_W'(1);
                        // ready drops together with the final all-level tick
                        if (cnt == LAST) begin
                            state     <= FLUSH;
                            rdy_q     <= 1'b0;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wavelet_level_scheduler.sv
// Bench for wavelet_level_scheduler: event-timeline reference model plus a per-cycle table for the 1-level build.
module tb_wavelet_level_scheduler;

    localparam int N_A = 16;
    localparam int F_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a;
    logic rstn_b;

    wavelet_level_scheduler_if #(.LEVELS(3), .CNT_W(4)) ifa ();
    wavelet_level_scheduler_if #(.LEVELS(1), .CNT_W(1)) ifb ();

    wavelet_level_scheduler #(
        .LEVELS    (3),
        .FRAME_LEN (N_A),
        .FLUSH_CYC (F_A)
    ) dut_a (
        .clk  (clk),
        .rstn (rstn_a),
        .bus  (ifa)
    );

    wavelet_level_scheduler #(
        .LEVELS    (1),
        .FRAME_LEN (2),
        .FLUSH_CYC (1)
    ) dut_b (
        .clk  (clk),
        .rstn (rstn_b),
        .bus  (ifb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame is "open" (ready) from the start until FRAME_LEN accepts, done lands
    // FLUSH_CYC+1 cycles after the last accept, and a start counts only once that cycle is past.
    bit         m_open;
    int         m_done_at;
    int         m_n;
    int         m_cyc;
    logic [2:0] m_tick;
    bit         m_acc;
    int         m_idx;
    int         tc[3];
    int         dc;
    int         acc_cnt;

    function automatic logic [2:0] ref_mask(input int i);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = ((i + 1) % (1 << (k + 1))) == 0;
        return r;
    endfunction

    task automatic model_reset();
        m_open    = 1'b0;
        m_done_at = -1;
        m_n       = 0;
        m_tick    = 3'b000;
        m_acc     = 1'b0;
        m_idx     = 0;
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 3; k++) tc[k] = 0;
        dc      = 0;
        acc_cnt = 0;
    endtask

    task automatic step_a(input bit st, input bit cl, input bit v);
        bit idle;
        ifa.start    = st;
        ifa.clr      = cl;
        ifa.in_valid = v;
        idle   = !m_open && (m_cyc > m_done_at);
        m_acc  = m_open && v && !cl;
        m_tick = m_acc ? ref_mask(m_n) : 3'b000;
        if (cl) begin
            m_open    = 1'b0;
            m_done_at = -1;
            m_n       = 0;
        end else begin
            if (st && idle) begin
                m_open = 1'b1;
                m_n    = 0;
            end
            if (m_acc) begin
                m_idx = m_n;
                m_n++;
                acc_cnt++;
                if (m_n == N_A) begin
                    m_open    = 1'b0;
                    m_done_at = m_cyc + 1 + F_A;
                end
            end
        end
        @(negedge clk);
        m_cyc++;
        chk("a_in_ready", ifa.in_ready, m_open);
        chk("a_lvl_en", ifa.lvl_en, m_tick);
        chk("a_done", ifa.done, m_cyc == m_done_at);
        chk("a_busy", ifa.busy, m_open || (m_cyc >= m_done_at - F_A && m_cyc < m_done_at));
        if (m_acc) chk("a_sample_idx", ifa.sample_idx, m_idx);
        for (int k = 0; k < 3; k++) tc[k] += int'(ifa.lvl_en[k]);
        dc += int'(ifa.done);
    endtask

    task automatic chk_counts(input string tag, input int e_acc, input int e_done);
        chk({tag, "_ticks_l0"}, tc[0], e_acc / 2);
        chk({tag, "_ticks_l1"}, tc[1], e_acc / 4);
        chk({tag, "_ticks_l2"}, tc[2], e_acc / 8);
        chk({tag, "_accepts"}, acc_cnt, e_acc);
        chk({tag, "_done_pulses"}, dc, e_done);
    endtask

    typedef struct {
        bit st;
        bit cl;
        bit v;
        bit e_rdy;
        bit e_lvl;
        bit e_done;
        bit e_busy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // 1-level, 2-sample, 1-cycle-flush build: per-cycle expectations
        tbl[0]  = '{1, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 1};
        tbl[2]  = '{0, 0, 1, 0, 1, 0, 1};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 1, 0, 0, 1};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, 0, 0, 1};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0};

        ifa.start = 0; ifa.clr = 0; ifa.in_valid = 0;
        ifb.start = 0; ifb.clr = 0; ifb.in_valid = 0;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        m_cyc  = 0;
        model_reset();
        clr_counts();
        @(negedge clk);
        chk("a_rst_ready", ifa.in_ready, 0);
        chk("a_rst_lvl", ifa.lvl_en, 0);
        chk("a_rst_idx", ifa.sample_idx, 0);
        chk("a_rst_busy", ifa.busy, 0);
        chk("a_rst_done", ifa.done, 0);
        chk("b_rst_ready", ifb.in_ready, 0);
        chk("b_rst_busy", ifb.busy, 0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // full-rate frame, with start retried mid-frame and in the DONE cycle
        step_a(0, 0, 1);
        clr_counts();
        step_a(1, 0, 1);
        for (int i = 0; i < 30; i++) step_a((m_open && m_n == 5) || (m_cyc == m_done_at), 0, 1);
        chk_counts("full", 16, 1);

        // alternating valid
        clr_counts();
        step_a(1, 0, 0);
        for (int i = 0; i < 45; i++) step_a(0, 0, (i % 2) == 0);
        chk_counts("toggle", 16, 1);

        // abort after 9 samples, then a clean frame
        clr_counts();
        step_a(1, 0, 1);
        for (int i = 0; i < 9; i++) step_a(0, 0, 1);
        step_a(0, 1, 1);
        for (int i = 0; i < 3; i++) step_a(0, 0, 1);
        chk_counts("abort", 9, 0);
        clr_counts();
        step_a(1, 0, 1);
        for (int i = 0; i < 25; i++) step_a(0, 0, 1);
        chk_counts("after_abort", 16, 1);

        // asynchronous reset while flushing
        step_a(1, 0, 1);
        for (int i = 0; i < 18; i++) step_a(0, 0, 1);
        chk("a_pre_rst_busy", ifa.busy, 1);
        #2 rstn_a = 1'b0;
        #1;
        model_reset();
        chk("a_arst_ready", ifa.in_ready, 0);
        chk("a_arst_lvl", ifa.lvl_en, 0);
        chk("a_arst_idx", ifa.sample_idx, 0);
        chk("a_arst_busy", ifa.busy, 0);
        chk("a_arst_done", ifa.done, 0);
        @(negedge clk);
        rstn_a = 1'b1;
        for (int i = 0; i < 5; i++) step_a(0, 0, 1);
        clr_counts();
        step_a(1, 0, 1);
        for (int i = 0; i < 25; i++) step_a(0, 0, 1);
        chk_counts("after_rst", 16, 1);

        // randomized traffic against the reference
        for (int i = 0; i < 800; i++) begin
            step_a($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        // edge build, table driven
        for (int i = 0; i < 13; i++) begin
            ifb.start    = tbl[i].st;
            ifb.clr      = tbl[i].cl;
            ifb.in_valid = tbl[i].v;
            @(negedge clk);
            chk($sformatf("b_ready_%0d", i), ifb.in_ready, tbl[i].e_rdy);
            chk($sformatf("b_lvl_%0d", i), ifb.lvl_en, tbl[i].e_lvl);
            chk($sformatf("b_done_%0d", i), ifb.done, tbl[i].e_done);
            chk($sformatf("b_busy_%0d", i), ifb.busy, tbl[i].e_busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
